// File: rtl/vdma_pkg.sv
// Shared definitions for the VDMA read-channel output stage.
package vdma_pkg;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      WAIT_FRAME = 2'd1,
      ACTIVE     = 2'd2,
      RESYNC     = 2'd3
   } state_t;

   localparam int UF_CNT_W = 16;

   // Timing bundle carried down the delay line; vs/hs are polarity-normalised.
   typedef struct packed {
      logic vs;
      logic hs;
      logic de;
      logic rd;
   } timing_t;

   function automatic logic [UF_CNT_W-1:0] sat_inc(input logic [UF_CNT_W-1:0] v);
      return (&v) ? v : v + UF_CNT_W'(1);
   endfunction

endpackage

// File: rtl/pixel_stream_out_timing_delay.sv
// Fixed-depth shift register for the timing bundle; matches unpacker read latency.
module timing_delay
   import vdma_pkg::*;
#(
   parameter int      DEPTH   = 1,
   parameter timing_t RST_VAL = '0
) (
   input  logic    clock,
   input  logic    rst_n,
   input  timing_t din,
   output timing_t dout
);

   timing_t stage_reg [DEPTH];

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            stage_reg[i] <= RST_VAL;
         end
      end else begin
         stage_reg[0] <= din;
         for (int i = 1; i < DEPTH; i++) begin
            stage_reg[i] <= stage_reg[i-1];
         end
      end
   end

   assign dout = stage_reg[DEPTH-1];

endmodule

// File: rtl/pixel_stream_out.sv
// VDMA read-path output stage: issues pixel reads against external timing,
// re-times unpacker data, and recovers from buffer underflow at the next frame.
module pixel_stream_out
   import vdma_pkg::*;
#(
   parameter int                  DSIZE   = 24,
   parameter int                  LAT     = 1,
   parameter bit                  VS_POL  = 1'b1,
   parameter bit                  HS_POL  = 1'b1,
   parameter logic [DSIZE-1:0]    BLANK   = '0,
   // Reset value of the underflow counter; nonzero only to exercise saturation.
   parameter logic [UF_CNT_W-1:0] UF_INIT = '0
) (
   input  logic                clock,
   input  logic                rst_n,
   input  logic                enable,
   input  logic                ivs,
   input  logic                ihs,
   input  logic                ide,
   input  logic                buf_empty,
   output logic                ord_en,
   output logic                ialign,
   output logic                force_rd,
   input  logic [DSIZE-1:0]    idata,
   output logic                ovs,
   output logic                ohs,
   output logic                ode,
   output logic [DSIZE-1:0]    odata,
   output logic                underflow,
   output logic [UF_CNT_W-1:0] uf_count
);

   // Delay-line contents that decode back to raw vs=hs=de=0.
   localparam timing_t DLY_RST = '{vs: ~VS_POL, hs: ~HS_POL, de: 1'b0, rd: 1'b0};

   state_t                state_reg, state_next;
   logic                  vs_act, hs_act;
   logic                  vs_prev_reg;
   logic                  fs;
   logic [UF_CNT_W-1:0]   uf_count_reg;
   timing_t               tim_in, tim_dly;

   assign vs_act = (ivs == VS_POL);
   assign hs_act = (ihs == HS_POL);
   assign fs     = vs_act & ~vs_prev_reg;

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= IDLE;
         vs_prev_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         vs_prev_reg <= vs_act;
      end
   end

   always_comb begin
      state_next = state_reg;
      ord_en     = 1'b0;
      ialign     = 1'b0;
      force_rd   = 1'b0;
      underflow  = 1'b0;
      if (!enable) begin
         state_next = IDLE;
      end else begin
         case (state_reg)
            IDLE: begin
               state_next = WAIT_FRAME;
            end
            WAIT_FRAME: begin
               if (fs) begin
                  ialign     = 1'b1;
                  state_next = ACTIVE;
               end
            end
            ACTIVE: begin
               ord_en = ide & ~buf_empty;
               // A frame start masks a same-cycle empty buffer: realign instead.
               if (fs) begin
                  ialign = 1'b1;
               end else if (ide && buf_empty) begin
                  underflow  = 1'b1;
                  state_next = RESYNC;
               end
            end
            RESYNC: begin
               if (fs) begin
                  ialign     = 1'b1;
                  force_rd   = 1'b1;
                  state_next = ACTIVE;
               end
            end
            default: begin
               state_next = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         uf_count_reg <= UF_INIT;
      end else if (underflow) begin
         uf_count_reg <= sat_inc(uf_count_reg);
      end
   end

   assign uf_count = uf_count_reg;

   assign tim_in = '{vs: vs_act, hs: hs_act, de: ide, rd: ord_en};

   timing_delay #(
      .DEPTH   (LAT),
      .RST_VAL (DLY_RST)
   ) u_timing_delay (
      .clock (clock),
      .rst_n (rst_n),
      .din   (tim_in),
      .dout  (tim_dly)
   );

   // The delayed rd lines up with the unpacker's registered pixel.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         ovs   <= 1'b0;
         ohs   <= 1'b0;
         ode   <= 1'b0;
         odata <= BLANK;
      end else begin
         ovs   <= tim_dly.vs ~^ VS_POL;
         ohs   <= tim_dly.hs ~^ HS_POL;
         ode   <= tim_dly.de;
         odata <= tim_dly.rd ? idata : BLANK;
      end
   end

endmodule

// File: tb/tb_pixel_stream_out.sv
// Frame-level bench: A (LAT=1), B (LAT=3, active-low vs), C (counter preloaded near saturation).
module tb_pixel_stream_out;
   import vdma_pkg::*;

   localparam int               DSIZE     = 24;
   localparam logic [DSIZE-1:0] GARBAGE   = 24'hEEEEEE;
   localparam int               HN        = 1024;
   localparam int               FRAME_LEN = 60;

   typedef struct {
      int          en_at;
      bit          drop_at_fs;
      int          uf_pix;
      int          rst_at;
      bit          exp_ialign;
      bit          exp_force;
      bit          exp_stream;
      int          exp_reads;
      logic [15:0] exp_uf_end;
   } frame_t;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic rst_n = 1'b1;
   logic enable = 1'b0, ivs = 1'b0, ihs = 1'b0, ide = 1'b0, buf_empty = 1'b0;
   logic ivs_b;
   assign ivs_b = ~ivs;

   logic             ord_en_a, ialign_a, force_rd_a, ovs_a, ohs_a, ode_a, underflow_a;
   logic             ord_en_b, ialign_b, force_rd_b, ovs_b, ohs_b, ode_b, underflow_b;
   logic             ord_en_c, ialign_c, force_rd_c, ovs_c, ohs_c, ode_c, underflow_c;
   logic [DSIZE-1:0] idata_a, idata_b, odata_a, odata_b, odata_c;
   logic [15:0]      uf_count_a, uf_count_b, uf_count_c;

   pixel_stream_out #(.DSIZE(DSIZE), .LAT(1)) u_dut_a (
      .clock(clock), .rst_n(rst_n), .enable(enable), .ivs(ivs), .ihs(ihs), .ide(ide),
      .buf_empty(buf_empty), .ord_en(ord_en_a), .ialign(ialign_a), .force_rd(force_rd_a),
      .idata(idata_a), .ovs(ovs_a), .ohs(ohs_a), .ode(ode_a), .odata(odata_a),
      .underflow(underflow_a), .uf_count(uf_count_a));

   pixel_stream_out #(.DSIZE(DSIZE), .LAT(3), .VS_POL(1'b0)) u_dut_b (
      .clock(clock), .rst_n(rst_n), .enable(enable), .ivs(ivs_b), .ihs(ihs), .ide(ide),
      .buf_empty(buf_empty), .ord_en(ord_en_b), .ialign(ialign_b), .force_rd(force_rd_b),
      .idata(idata_b), .ovs(ovs_b), .ohs(ohs_b), .ode(ode_b), .odata(odata_b),
      .underflow(underflow_b), .uf_count(uf_count_b));

   pixel_stream_out #(.DSIZE(DSIZE), .LAT(1), .UF_INIT(16'hFFFE)) u_dut_c (
      .clock(clock), .rst_n(rst_n), .enable(enable), .ivs(ivs), .ihs(ihs), .ide(ide),
      .buf_empty(buf_empty), .ord_en(ord_en_c), .ialign(ialign_c), .force_rd(force_rd_c),
      .idata(idata_a), .ovs(ovs_c), .ohs(ohs_c), .ode(ode_c), .odata(odata_c),
      .underflow(underflow_c), .uf_count(uf_count_c));

   // Unpacker models: the k-th pixel read returns value k, garbage when not read.
   int               rcnt_a = 0;
   int               rcnt_b = 0;
   logic [DSIZE-1:0] pipe_b [3];
   always @(posedge clock) begin
      if (ord_en_a) rcnt_a <= rcnt_a + 1;
      idata_a <= ord_en_a ? DSIZE'(rcnt_a + 1) : GARBAGE;
      if (ord_en_b) rcnt_b <= rcnt_b + 1;
      pipe_b[0] <= ord_en_b ? DSIZE'(rcnt_b + 1) : GARBAGE;
      pipe_b[1] <= pipe_b[0];
      pipe_b[2] <= pipe_b[1];
   end
   assign idata_b = pipe_b[2];

   int               checks = 0;
   int               errors = 0;
   int               cyc = 8;
   int               exp_rd = 0;
   int               frame_reads = 0;
   logic [4:0]       hist [HN];   // {vs_b, vs, hs, de, rd} as driven each cycle
   logic [DSIZE-1:0] pixv [HN];
   logic             e_ord = 1'b0, e_ial = 1'b0, e_frc = 1'b0, e_uf = 1'b0;
   logic [15:0]      exp_uf = 16'd0;
   logic [15:0]      exp_uf_c = 16'hFFFE;
   frame_t           frames [8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
      end
   endtask

   // Inputs and e_* are set by the caller just after a rising edge.
   task automatic step();
      logic [4:0]       h2, h4;
      logic [DSIZE-1:0] d2, d4;
      #4;
      if (!rst_n) begin
         for (int k = 0; k <= 4; k++) hist[cyc-k] = '0;
         exp_uf   = 16'd0;
         exp_uf_c = 16'hFFFE;
      end else begin
         hist[cyc] = {ivs_b, ivs, ihs, ide, e_ord};
         if (e_ord) begin
            exp_rd++;
            pixv[cyc] = DSIZE'(exp_rd);
         end
      end
      h2 = hist[cyc-2];
      h4 = hist[cyc-4];
      d2 = h2[0] ? pixv[cyc-2] : '0;
      d4 = h4[0] ? pixv[cyc-4] : '0;
      chk("ord_en_a", ord_en_a, e_ord);
      chk("ialign_a", ialign_a, e_ial);
      chk("force_rd_a", force_rd_a, e_frc);
      chk("underflow_a", underflow_a, e_uf);
      chk("uf_count_a", uf_count_a, exp_uf);
      chk("ovs_a", ovs_a, h2[3]);
      chk("ohs_a", ohs_a, h2[2]);
      chk("ode_a", ode_a, h2[1]);
      chk("odata_a", odata_a, d2);
      chk("ord_en_b", ord_en_b, e_ord);
      chk("ialign_b", ialign_b, e_ial);
      chk("force_rd_b", force_rd_b, e_frc);
      chk("underflow_b", underflow_b, e_uf);
      chk("uf_count_b", uf_count_b, exp_uf);
      chk("ovs_b", ovs_b, h4[4]);
      chk("ohs_b", ohs_b, h4[2]);
      chk("ode_b", ode_b, h4[1]);
      chk("odata_b", odata_b, d4);
      chk("ord_en_c", ord_en_c, e_ord);
      chk("ialign_c", ialign_c, e_ial);
      chk("force_rd_c", force_rd_c, e_frc);
      chk("underflow_c", underflow_c, e_uf);
      chk("uf_count_c", uf_count_c, exp_uf_c);
      chk("ovs_c", ovs_c, h2[3]);
      chk("ohs_c", ohs_c, h2[2]);
      chk("ode_c", ode_c, h2[1]);
      chk("odata_c", odata_c, d2);
      if (e_uf) begin
         exp_uf   = (exp_uf == 16'hFFFF) ? exp_uf : exp_uf + 16'd1;
         exp_uf_c = (exp_uf_c == 16'hFFFF) ? exp_uf_c : exp_uf_c + 16'd1;
      end
      if (ord_en_a === 1'b1) frame_reads++;
      cyc++;
      @(posedge clock);
      #1;
   endtask

   // Frame: fs at c=4, four lines of 13 cycles from c=8 with 8 de cycles each.
   task automatic run_frame(input frame_t f);
      int pix;
      int lc;
      bit stream;
      pix         = 0;
      stream      = 1'b0;
      frame_reads = 0;
      for (int c = 0; c < FRAME_LEN; c++) begin
         lc  = (c >= 8) ? (c - 8) % 13 : 0;
         ivs = (c == 4 || c == 5);
         ihs = (c >= 8) && (lc < 2);
         ide = (c >= 8) && (lc >= 3) && (lc < 11);
         if (c == f.en_at) enable = 1'b1;
         if (c == 4 && f.drop_at_fs) enable = 1'b0;
         rst_n     = !(c >= f.rst_at && c < f.rst_at + 3);
         buf_empty = ide && (pix == f.uf_pix);
         e_ord = 1'b0;
         e_ial = 1'b0;
         e_frc = 1'b0;
         e_uf  = 1'b0;
         if (!rst_n) begin
            stream = 1'b0;
         end else if (c == 4) begin
            e_ial  = f.exp_ialign;
            e_frc  = f.exp_force;
            stream = f.exp_stream;
         end else if (ide && stream) begin
            if (buf_empty) begin
               e_uf   = 1'b1;
               stream = 1'b0;
            end else begin
               e_ord = 1'b1;
            end
         end
         if (ide) pix++;
         step();
      end
   endtask

   initial begin
      // en_at  drop  uf_pix rst_at  ialign force stream reads uf_end
      frames[0] = '{en_at:30, drop_at_fs:0, uf_pix:-1, rst_at:-10, exp_ialign:0, exp_force:0, exp_stream:0, exp_reads:0,  exp_uf_end:16'd0};
      frames[1] = '{en_at:-1, drop_at_fs:0, uf_pix:-1, rst_at:-10, exp_ialign:1, exp_force:0, exp_stream:1, exp_reads:32, exp_uf_end:16'd0};
      frames[2] = '{en_at:-1, drop_at_fs:0, uf_pix:4,  rst_at:-10, exp_ialign:1, exp_force:0, exp_stream:1, exp_reads:4,  exp_uf_end:16'd1};
      frames[3] = '{en_at:-1, drop_at_fs:0, uf_pix:20, rst_at:-10, exp_ialign:1, exp_force:1, exp_stream:1, exp_reads:20, exp_uf_end:16'd2};
      frames[4] = '{en_at:-1, drop_at_fs:0, uf_pix:-1, rst_at:-10, exp_ialign:1, exp_force:1, exp_stream:1, exp_reads:32, exp_uf_end:16'd2};
      frames[5] = '{en_at:-1, drop_at_fs:1, uf_pix:-1, rst_at:-10, exp_ialign:0, exp_force:0, exp_stream:0, exp_reads:0,  exp_uf_end:16'd2};
      frames[6] = '{en_at:0,  drop_at_fs:0, uf_pix:-1, rst_at:27,  exp_ialign:1, exp_force:0, exp_stream:1, exp_reads:11, exp_uf_end:16'd0};
      frames[7] = '{en_at:-1, drop_at_fs:0, uf_pix:-1, rst_at:-10, exp_ialign:1, exp_force:0, exp_stream:1, exp_reads:32, exp_uf_end:16'd0};
      for (int i = 0; i < HN; i++) begin
         hist[i] = '0;
         pixv[i] = '0;
      end

      #1 rst_n = 1'b0;
      @(posedge clock);
      #1;
      for (int i = 0; i < 4; i++) step();
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) step();
      chk("rst_uf_count_a", uf_count_a, 16'd0);
      chk("rst_odata_a", odata_a, '0);

      for (int i = 0; i < 8; i++) begin
         run_frame(frames[i]);
         chk("frame_reads", frame_reads, frames[i].exp_reads);
         chk("frame_uf_count", uf_count_a, frames[i].exp_uf_end);
         $display("frame %0d: reads=%0d uf_count_a=%0h uf_count_c=%0h", i, frame_reads, uf_count_a, uf_count_c);
      end

      ivs = 1'b0;
      ihs = 1'b0;
      ide = 1'b0;
      buf_empty = 1'b0;
      e_ord = 1'b0;
      e_ial = 1'b0;
      e_frc = 1'b0;
      e_uf  = 1'b0;
      for (int i = 0; i < 8; i++) step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
